stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N-channel, W-bit stream multiplexer with a registered output stage and per-channel valid/ready handshake. Channel choice comes either from an explicit select input or from a built-in round-robin arbiter, chosen per cycle by a mode input. The block replaces ad-hoc 2:1 selectors wherever several producers share one consumer, for example display or datapath sources feeding a single sink.

## Interface
Parameters:
- `WIDTH`, 2, data width per channel (≥1).
- `CHANNELS`, 4, number of input channels (≥2).
- `SELW`, `$clog2(CHANNELS)`, select/channel-index width (derived; do not override).

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  input  CHANNELS  per-channel valid.
- `in_ready`  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- `mode`  input  1  0 = explicit select, 1 = round-robin.
- `sel`  input  SELW  channel index used when `mode`=0.
- `out_data`  output  WIDTH  registered data.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts a word.
- `out_chan`  output  SELW  source channel of the word in `out_data`.

## Operation
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_load` = EMPTY or (FULL and `out_ready`).
- Candidate grant g:
  - `mode`=0: g = `sel`, valid only if `sel` < CHANNELS and `in_valid[sel]`=1.
  - `sel` ≥ CHANNELS: no grant.
  - `mode`=1: g is the first k with `in_valid[k]`=1, scanning `last`+1, `last`+2, … modulo CHANNELS.
- `in_ready[g]` = `can_load` when g is valid. All other `in_ready` bits are 0. `in_ready` may depend combinationally on `out_ready`, `mode`, `sel` and `in_valid`.
- Accept: `in_valid[g]` and `in_ready[g]`. On accept:
  - `out_data` ← channel g data, `out_chan` ← g, `out_valid` ← 1.
  - `last` ← g. This happens in both modes, so a switch to round-robin resumes after the last served channel.
- FULL with `out_ready`=1 and no accept → EMPTY.
- FULL with `out_ready`=0: `out_data`, `out_chan` and `out_valid` are held stable regardless of `sel`, `mode` or input changes.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, with no bubble.
- `mode`/`sel` changes take effect at the next accept only. They never alter a held word.
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `last`=CHANNELS-1, so channel 0 has first round-robin priority. While `rst`=1, all `in_ready`=0.
- Reset asserted mid-transfer discards the held word immediately; nothing is replayed.

## Timing
- Latency: accept at edge n → `out_valid`=1 with that word after edge n.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- No combinational path from `in_data` to `out_data`.
- Combinational paths exist from `out_ready`/`in_valid`/`sel`/`mode` to `in_ready` only.
- Round-robin fairness: with all channels valid and `out_ready`=1, grants cycle 0,1,…,CHANNELS-1,0,… one per cycle.
- Async reset clears state without waiting for `clk`. Release is synchronous to the next `clk` edge by the board-level reset synchroniser, not by this block.

## Structure
- Shared package `stream_mux_pkg`: constants `MODE_SEL`=1'b0, `MODE_RR`=1'b1.
- Sub-module `rr_pick`: a purely combinational rotating-priority picker.
  - Inputs: request vector, `last` index.
  - Outputs: grant index plus a grant-valid bit.
  - Parametrised by CHANNELS.
- Top level holds `last`, the output register, select-mode decode and ready generation.

## Test plan
- Reset: assert `rst` with all inputs active → `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0000. After release with `mode`=1 and all valid → first grant is channel 0.
- Explicit select, WIDTH=2, CHANNELS=4: `mode`=0, `sel`=2, channel 2 data 2'b10, valid, `out_ready`=1 → next cycle `out_data`=10, `out_chan`=2. Set `sel`=3 (channel 3 invalid) → `in_ready`=0000, `out_valid` drops after drain.
- Backpressure: word held with `out_ready`=0 for 5 cycles while `sel` and inputs toggle → `out_data`/`out_chan` unchanged and `in_ready`=0000. Raise `out_ready` → new word loads in the same edge as the drain.
- Round-robin: `mode`=1, `in_valid`=1111, `out_ready`=1 for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3. With `in_valid`=1010 → alternates 1,3.
- Mode switch: accept channel 2 in `mode`=0, then switch to `mode`=1 with all valid → next grant is channel 3.
- Reset mid-operation: `rst` pulsed between clock edges while FULL → `out_valid` falls before the next edge. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the stream multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_mux_pkg;

    // Values of the per-cycle mode input
    localparam logic MODE_SEL = 1'b0;   // channel comes from the explicit select
    localparam logic MODE_RR  = 1'b1;   // channel comes from the round-robin picker

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/stream_mux_if.sv
// Bundle of the producer-side and consumer-side handshake signals of stream_mux.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry it; see stream_mux.
// Ports: in_data/in_valid/in_ready per channel, mode/sel channel choice,
//        out_data/out_valid/out_ready/out_chan registered output side.
interface stream_mux_if #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;    // channel k at [k*WIDTH +: WIDTH]
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;   // at most one bit high
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SELW-1:0]           out_chan;

    // Environment side: producers plus the single consumer
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

endinterface

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority picker: first requester strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is accepted.
// Ports: req (request vector), last (previously served index),
//        gnt (picked index), gnt_vld (some request present).
module rr_pick #(
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     last,
    output logic [SELW-1:0]     gnt,
    output logic                gnt_vld
);

    always_comb begin
        int              idx;
        logic [SELW-1:0] cand;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        // Walk from the farthest offset to the nearest so the requester
        // closest after 'last' overwrites any earlier hit and wins.
        for (int i = CHANNELS; i >= 1; i--) begin
            idx  = (int'(last) + i) % CHANNELS;
            cand = SELW'(idx);
            if (req[cand]) begin
                gnt     = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel stream multiplexer with one registered output word; channel by select or round-robin.
// Latency: one cycle from accept to out_valid; one word per cycle sustained.
// Backpressure: out_ready low holds the word and drops all in_ready; drain and refill share an edge.
// Ports: clk, rst (async active-high), bus (stream_mux_if.slave: inputs, mode/sel, registered output).
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic         clk,
    input  logic         rst,
    stream_mux_if.slave  bus
);

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  chan_q;
    logic [SELW-1:0]  last_q;      // last served channel, shared by both modes

    logic [SELW-1:0]     rr_gnt;
    logic                rr_vld;
    logic                sel_vld;
    logic [SELW-1:0]     gnt;
    logic                gnt_vld;
    logic                can_load;
    logic                accept;
    logic [CHANNELS-1:0] ready;

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .req     (bus.in_valid),
        .last    (last_q),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // Explicit select: an index beyond the channel count never grants.
    always_comb begin
        sel_vld = 1'b0;
        if (int'(bus.sel) < CHANNELS) begin
            sel_vld = bus.in_valid[bus.sel];
        end
    end

    always_comb begin
        gnt     = bus.sel;
        gnt_vld = sel_vld;
        if (bus.mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end
    end

    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;
    // Both grant sources only report channels whose valid is high, so a
    // granted and loadable channel is accepted. Reset masks every ready.
    assign accept   = gnt_vld && can_load && !rst;

    always_comb begin
        ready = '0;
        if (accept) begin
            ready[gnt] = 1'b1;
        end
    end

    assign bus.in_ready = ready;

    // Occupancy FSM: an accept always leaves the register full, even when
    // the previous word drains on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && bus.out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // last resets to the top index so channel 0 is first in round-robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            chan_q <= '0;
            last_q <= SELW'(CHANNELS - 1);
        end else if (accept) begin
            data_q <= bus.in_data[gnt*WIDTH +: WIDTH];
            chan_q <= gnt;
            last_q <= gnt;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux with a scoreboard of expected output words.
// Latency: n/a.
// Backpressure: n/a.
module tb_stream_mux;
    import stream_mux_pkg::*;

    localparam int WIDTH    = 2;
    localparam int CHANNELS = 4;

    typedef struct packed {
        logic [1:0] chan;
        logic [1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst;

    stream_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    stream_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    word_t      exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] chdat [4];
    logic [7:0] base_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called when the consumer takes a word: it must be the oldest expected one.
    task automatic pop_check();
        word_t w;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL sb_unexpected observed chan=%0d data=%b expected=no word",
                   bus.out_chan, bus.out_data);
        end
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("sb_chan", 32'(bus.out_chan), 32'(w.chan));
            check("sb_data", 32'(bus.out_data), 32'(w.data));
        end
    endtask

    // Consume-side check just before the edge, then step to 1 after the edge.
    task automatic tick();
        #1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int ch);
        word_t w;
        w.chan = 2'(ch);
        w.data = chdat[ch];
        exp_q.push_back(w);
    endtask

    initial begin
        chdat[0]  = 2'b11;
        chdat[1]  = 2'b01;
        chdat[2]  = 2'b10;
        chdat[3]  = 2'b00;
        base_data = {chdat[3], chdat[2], chdat[1], chdat[0]};

        // Reset with every input active
        rst           = 1'b1;
        bus.mode      = MODE_RR;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = base_data;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_chan",  32'(bus.out_chan),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b0;

        // Round-robin, all channels valid: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr4_ready", 32'(bus.in_ready), 32'(4'b0001 << (i % 4)));
            expect_word(i % 4);
            tick();
        end

        // Round-robin with channels 1 and 3 valid: alternates 1,3
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr2_ready", 32'(bus.in_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
            expect_word((i % 2 == 0) ? 1 : 3);
            tick();
        end

        // Explicit select of channel 2
        bus.mode     = MODE_SEL;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b0100;
        #1;
        check("sel2_ready", 32'(bus.in_ready), 32'h4);
        expect_word(2);
        tick();
        check("sel2_out_data",  32'(bus.out_data),  32'h2);
        check("sel2_out_chan",  32'(bus.out_chan),  32'd2);
        check("sel2_out_valid", 32'(bus.out_valid), 32'd1);

        // Select an invalid channel: no grant, register drains
        bus.sel = 2'd3;
        #1;
        check("sel3_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("sel3_drained", 32'(bus.out_valid), 32'd0);

        // Switch to round-robin after serving channel 2: channel 3 next
        bus.mode     = MODE_RR;
        bus.in_valid = 4'b1111;
        #1;
        check("switch_ready", 32'(bus.in_ready), 32'h8);
        expect_word(3);
        tick();
        check("switch_chan", 32'(bus.out_chan), 32'd3);

        // Backpressure: word held while select, mode and inputs move
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sel      = 2'(i);
            bus.mode     = i[0];
            bus.in_valid = 4'(i + 9);
            bus.in_data  = 8'($urandom);
            #1;
            check("bp_ready", 32'(bus.in_ready), 32'h0);
            tick();
            check("bp_data",  32'(bus.out_data),  32'(chdat[3]));
            check("bp_chan",  32'(bus.out_chan),  32'd3);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
        end

        // Release: drain and load of channel 1 on the same edge
        bus.in_data   = base_data;
        bus.mode      = MODE_SEL;
        bus.sel       = 2'd1;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b1;
        #1;
        check("release_ready", 32'(bus.in_ready), 32'h2);
        expect_word(1);
        tick();
        check("nobubble_valid", 32'(bus.out_valid), 32'd1);
        check("nobubble_chan",  32'(bus.out_chan),  32'd1);

        // Reset between edges while full: held word is discarded at once
        bus.out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_data",  32'(bus.out_data),  32'd0);
        check("midrst_chan",  32'(bus.out_chan),  32'd0);
        check("midrst_ready", 32'(bus.in_ready),  32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin restarts at channel 0
        bus.mode      = MODE_RR;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        check("restart_ready0", 32'(bus.in_ready), 32'h1);
        expect_word(0);
        tick();
        #1;
        check("restart_ready1", 32'(bus.in_ready), 32'h2);
        expect_word(1);
        tick();
        bus.in_valid = 4'b0000;
        tick();
        check("final_valid", 32'(bus.out_valid), 32'd0);
        check("sb_all_seen", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
